// File: rtl/kmp_search_pe_pkg.sv
// kmp_search_pe_pkg: shared widths and FSM encoding for the KMP search PEs.
// Optional build macro: KMP_PE_STAT_EN (per-job cycle counter output).
package kmp_search_pe_pkg;

    localparam int MAX_STR_ADD = 8;
    localparam int MAX_PAT_ADD = 3;
    localparam int NUM_PE      = 4;
    localparam int CHAR_W      = 8;

    typedef enum logic [1:0] {
        KMP_PE_IDLE    = 2'd0,
        KMP_PE_FETCH   = 2'd1,
        KMP_PE_COMPARE = 2'd2,
        KMP_PE_DONE    = 2'd3
    } kmp_pe_state_e;

endpackage

// File: rtl/kmp_search_pe_if.sv
// kmp_search_pe_if: job request and result bundle between control unit and PE.
// Optional build macro: KMP_PE_STAT_EN adds o_cycle_cnt.
interface kmp_search_pe_if
    import kmp_search_pe_pkg::*;
#(
    parameter int STR_AW  = MAX_STR_ADD,
    parameter int PAT_AW  = MAX_PAT_ADD,
    parameter int PAT_LEN = 1 << MAX_PAT_ADD,
    parameter int CW      = CHAR_W
);
    logic                      pe_valid;
    logic [STR_AW-1:0]         start_idx;
    logic [STR_AW-1:0]         end_idx;
    logic [PAT_AW-1:0]         pat_last_idx;
    logic [PAT_LEN*CW-1:0]     pat_chars;
    logic [PAT_LEN*PAT_AW-1:0] fail_tbl;
    logic                      o_match_valid;
    logic                      o_match;
    logic [STR_AW-1:0]         o_match_idx;
`ifdef KMP_PE_STAT_EN
    logic [15:0]               o_cycle_cnt;
`endif

    modport master (
        output pe_valid, start_idx, end_idx,
        output pat_last_idx, pat_chars, fail_tbl,
`ifdef KMP_PE_STAT_EN
        input  o_cycle_cnt,
`endif
        input  o_match_valid, o_match, o_match_idx
    );

    modport slave (
        input  pe_valid, start_idx, end_idx,
        input  pat_last_idx, pat_chars, fail_tbl,
`ifdef KMP_PE_STAT_EN
        output o_cycle_cnt,
`endif
        output o_match_valid, o_match, o_match_idx
    );

endinterface

// File: rtl/kmp_search_pe.sv
// kmp_search_pe: scans one string segment with KMP, reports the first match.
// Optional build macro: KMP_PE_STAT_EN adds a saturating busy-cycle counter.
module kmp_search_pe
    import kmp_search_pe_pkg::*;
#(
    parameter int STR_AW  = MAX_STR_ADD,
    parameter int PAT_AW  = MAX_PAT_ADD,
    parameter int PAT_LEN = 1 << MAX_PAT_ADD,
    parameter int CW      = CHAR_W
) (
    input  logic              clk,
    input  logic              reset,
    kmp_search_pe_if.slave    job,
    output logic [STR_AW-1:0] str_raddr,
    input  logic [CW-1:0]     str_rdata
);

    kmp_pe_state_e     state_q, state_d;
    logic [STR_AW-1:0] i_q, i_d;
    logic [STR_AW-1:0] end_q, end_d;
    logic [PAT_AW-1:0] j_q, j_d;
    logic [PAT_AW-1:0] last_q, last_d;
    logic [PAT_AW-1:0] jm1;
    logic [CW-1:0]     ch_q, ch;
    logic              first_q;
    logic              hit;
    logic [STR_AW-1:0] idx_d;
    logic              valid_q, match_q;
    logic [STR_AW-1:0] idx_q;
    logic [CW-1:0]     pat_arr  [PAT_LEN];
    logic [PAT_AW-1:0] fail_arr [PAT_LEN];

    // Unpack the flat pattern and failure-table buses into arrays
    always_comb begin
        for (int k = 0; k < PAT_LEN; k++) begin
            pat_arr[k]  = job.pat_chars[k*CW +: CW];
            fail_arr[k] = job.fail_tbl[k*PAT_AW +: PAT_AW];
        end
    end

    // The fresh read word is only on the bus right after FETCH
    assign ch  = first_q ? str_rdata : ch_q;
    assign jm1 = j_q - PAT_AW'(1);

    assign str_raddr = (state_q == KMP_PE_FETCH) ? i_q : '0;

    // Next-state logic: KMP step, end-of-segment test, abort on pe_valid drop
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        end_d   = end_q;
        last_d  = last_q;
        hit     = 1'b0;
        idx_d   = '0;
        unique case (state_q)
            KMP_PE_IDLE: begin
                if (job.pe_valid) begin
                    if (job.start_idx > job.end_idx) begin
                        state_d = KMP_PE_DONE;
                    end else begin
                        i_d     = job.start_idx;
                        j_d     = '0;
                        end_d   = job.end_idx;
                        last_d  = job.pat_last_idx;
                        state_d = KMP_PE_FETCH;
                    end
                end
            end
            KMP_PE_FETCH: state_d = KMP_PE_COMPARE;
            KMP_PE_COMPARE: begin
                if (ch == pat_arr[j_q] && j_q == last_q) begin
                    hit     = 1'b1;
                    idx_d   = i_q - STR_AW'(last_q);
                    state_d = KMP_PE_DONE;
                end else if (ch != pat_arr[j_q] && j_q != '0) begin
                    j_d = fail_arr[jm1];
                end else begin
                    if (ch == pat_arr[j_q]) j_d = j_q + 1'b1;
                    if (i_q == end_q) begin
                        state_d = KMP_PE_DONE;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = KMP_PE_FETCH;
                    end
                end
            end
            KMP_PE_DONE: state_d = KMP_PE_DONE;
            default:     state_d = KMP_PE_IDLE;
        endcase
        if (!job.pe_valid) state_d = KMP_PE_IDLE;
    end

    // State, scan registers and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= KMP_PE_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            end_q   <= '0;
            last_q  <= '0;
            ch_q    <= '0;
            first_q <= 1'b0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            end_q   <= end_d;
            last_q  <= last_d;
            first_q <= (state_q == KMP_PE_FETCH);
            if (first_q) ch_q <= str_rdata;
            if (state_d == KMP_PE_IDLE) begin
                valid_q <= 1'b0;
                match_q <= 1'b0;
                idx_q   <= '0;
            end else if (state_q != KMP_PE_DONE && state_d == KMP_PE_DONE) begin
                valid_q <= 1'b1;
                match_q <= hit;
                idx_q   <= idx_d;
            end
        end
    end

    assign job.o_match_valid = valid_q;
    assign job.o_match       = match_q;
    assign job.o_match_idx   = idx_q;

`ifdef KMP_PE_STAT_EN
    logic [15:0] cnt_q;

    // Busy-cycle counter, saturating, frozen in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == KMP_PE_IDLE || state_d == KMP_PE_IDLE) begin
            cnt_q <= '0;
        end else if ((state_q == KMP_PE_FETCH || state_q == KMP_PE_COMPARE)
                     && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign job.o_cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_kmp_search_pe.sv
// tb_kmp_search_pe: directed and random KMP segment searches against a naive model.
// Optional build macro: KMP_PE_STAT_EN also checks the busy-cycle counter.
module tb_kmp_search_pe;
    import kmp_search_pe_pkg::*;

    localparam int SAW = MAX_STR_ADD;
    localparam int PAW = MAX_PAT_ADD;
    localparam int PL  = 1 << MAX_PAT_ADD;
    localparam int CW  = CHAR_W;
    localparam int MEMD = 1 << SAW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [SAW-1:0] str_raddr;
    logic [CW-1:0]  str_rdata = '0;
    logic [CW-1:0]  mem [MEMD];
    logic [CW-1:0]  pat [PL];
    int plen;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kmp_search_pe_if bus ();

    kmp_search_pe dut (
        .clk       (clk),
        .reset     (reset),
        .job       (bus),
        .str_raddr (str_raddr),
        .str_rdata (str_rdata)
    );

    always @(posedge clk) str_rdata <= mem[str_raddr];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pfx(int k);
        for (int l = k; l >= 1; l--) begin
            bit ok = 1;
            for (int t = 0; t < l; t++)
                if (pat[t] != pat[k-l+1+t]) ok = 0;
            if (ok) return l;
        end
        return 0;
    endfunction

    task automatic set_pattern(string p);
        plen = p.len();
        for (int k = 0; k < PL; k++) pat[k] = (k < plen) ? p[k] : 8'h00;
        bus.pat_chars = '0;
        bus.fail_tbl  = '0;
        for (int k = 0; k < PL; k++) begin
            bus.pat_chars[k*CW +: CW]   = pat[k];
            bus.fail_tbl[k*PAW +: PAW]  = PAW'(pfx(k));
        end
        bus.pat_last_idx = PAW'(plen - 1);
    endtask

    task automatic load_str(string s, int base);
        for (int k = 0; k < MEMD; k++) mem[k] = 8'h00;
        for (int k = 0; k < s.len(); k++) mem[base+k] = s[k];
    endtask

    task automatic model(input int s, input int e, output bit found,
                         output int idx, output int busy);
        int j, cons, fb;
        bit done;
        found = 0;
        idx = 0;
        for (int k = s; k + plen - 1 <= e && !found; k++) begin
            bit eq = 1;
            for (int t = 0; t < plen; t++)
                if (mem[k+t] != pat[t]) eq = 0;
            if (eq) begin found = 1; idx = k; end
        end
        j = 0; cons = 0; fb = 0; done = 0;
        for (int i = s; i <= e && !done; i++) begin
            cons++;
            while (j > 0 && mem[i] != pat[j]) begin
                j = pfx(j - 1);
                fb++;
            end
            if (mem[i] == pat[j]) begin
                if (j == plen - 1) done = 1;
                else j++;
            end
        end
        busy = 2 * cons + fb;
    endtask

    task automatic run_job(string tag, int s, int e,
                           output bit got_m, output int got_idx);
        bit mf, act;
        int mi, busy, n;
        model(s, e, mf, mi, busy);
        @(negedge clk);
        bus.start_idx = SAW'(s);
        bus.end_idx   = SAW'(e);
        bus.pe_valid  = 1'b1;
        n = 0;
        act = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (str_raddr != '0) act = 1;
        end while (!bus.o_match_valid && n < 2000);
        got_m   = bus.o_match;
        got_idx = int'(bus.o_match_idx);
        check($sformatf("%s valid", tag), 32'(bus.o_match_valid), 32'd1);
        check($sformatf("%s latency", tag), 32'(n), 32'(busy + 1));
        check($sformatf("%s match", tag), 32'(bus.o_match), 32'(mf));
        check($sformatf("%s idx", tag), 32'(bus.o_match_idx), 32'(mi));
        if (s > e) check($sformatf("%s raddr_idle", tag), 32'(act), 32'd0);
`ifdef KMP_PE_STAT_EN
        check($sformatf("%s cyc", tag), 32'(bus.o_cycle_cnt), 32'(busy));
`endif
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("%s hold_valid", tag), 32'(bus.o_match_valid), 32'd1);
        check($sformatf("%s hold_idx", tag), 32'(bus.o_match_idx), 32'(mi));
        @(negedge clk);
        bus.pe_valid = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("%s clr_valid", tag), 32'(bus.o_match_valid), 32'd0);
        check($sformatf("%s clr_out", tag),
              32'({bus.o_match, bus.o_match_idx}), 32'd0);
    endtask

    initial begin
        bit gm;
        int gi, s, e, n, seen;
        string p;
        bus.pe_valid = 1'b0;
        bus.start_idx = '0;
        bus.end_idx = '0;
        load_str("", 0);
        set_pattern("A");
        repeat (3) @(posedge clk);
        #1;
        check("reset valid", 32'(bus.o_match_valid), 32'd0);
        check("reset out", 32'({bus.o_match, bus.o_match_idx}), 32'd0);
        check("reset raddr", 32'(str_raddr), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        load_str("ABCABD", 0);
        set_pattern("ABD");
        run_job("abd", 0, 5, gm, gi);
        check("abd idx3", 32'(gi), 32'd3);

        load_str("AAAAB", 0);
        set_pattern("AAB");
        run_job("aab", 0, 4, gm, gi);
        check("aab idx2", 32'(gi), 32'd2);

        load_str("ABCDEF", 0);
        set_pattern("XY");
        run_job("xy", 2, 5, gm, gi);
        check("xy nomatch", 32'(gm), 32'd0);

        run_job("empty", 4, 3, gm, gi);

        load_str("ABCABD", 0);
        set_pattern("ABD");
        @(negedge clk);
        bus.start_idx = '0;
        bus.end_idx = SAW'(5);
        bus.pe_valid = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.pe_valid = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.o_match_valid) seen = 1;
        end
        check("abort valid", 32'(seen), 32'd0);
        check("abort out", 32'({bus.o_match, bus.o_match_idx}), 32'd0);
        @(negedge clk);
        bus.pe_valid = 1'b1;
        @(posedge clk);
        #1;
        check("fetch raddr", 32'(str_raddr), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst mid valid", 32'(bus.o_match_valid), 32'd0);
        check("rst mid out", 32'({bus.o_match, bus.o_match_idx}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.pe_valid = 1'b0;
        @(posedge clk);

        load_str("ZAB", 0);
        set_pattern("AB");
        run_job("zab", 0, 2, gm, gi);
        check("zab idx1", 32'(gi), 32'd1);

        load_str("BBBBBAB", MEMD - 7);
        set_pattern("BAB");
        run_job("top", MEMD - 8, MEMD - 1, gm, gi);
        check("top idx", 32'(gi), 32'(MEMD - 3));

        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < MEMD; k++)
                mem[k] = 8'h41 + 8'($urandom_range(0, 2));
            n = $urandom_range(1, 4);
            p = "";
            for (int k = 0; k < n; k++)
                p = {p, ($urandom_range(0, 1) != 0) ? "A" : "B"};
            set_pattern(p);
            s = $urandom_range(0, MEMD - 1);
            e = s + $urandom_range(0, 24);
            if (e > MEMD - 1) e = MEMD - 1;
            if ($urandom_range(0, 9) == 0) e = s - 1;
            if (e < 0) e = 0;
            run_job($sformatf("rnd%0d", it), s, e, gm, gi);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
